// File: rtl/lane_dly_pkg.sv
// lane_dly_pkg: shared FSM states and completion status codes for the lane delay-line sequencer
package lane_dly_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_MOVE, S_GAP, S_HOLD, S_DONE} state_t;
  localparam logic [1:0] ST_OK = 2'b00, ST_OOR = 2'b01, ST_CLAMP = 2'b10;
endpackage

// File: rtl/lane_dly_wait_cnt.sv
// lane_dly_wait_cnt: loadable down-counter; expired while the count sits at zero
module lane_dly_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= rst ? '0 : load ? val : cnt - W'(cnt != '0);
  assign expired = cnt == '0;
endmodule

// File: rtl/lane_dly_step_ctrl.sv
// lane_dly_step_ctrl: steps one DDR4 lane delay line under HS_IO_CLK_PAUSE and tracks tap positions
// Optional LANE_DLY_LOAD_EN: REQ_LOAD reloads the selected line to its INIT tap with one LOAD pulse.
module lane_dly_step_ctrl
  import lane_dly_pkg::*;
#(
  parameter int TAP_W       = 8,
  parameter int MAX_TAP     = 127,
  parameter int INIT_TAP_TX = 1,
  parameter int INIT_TAP_RX = 1,
  parameter int PAUSE_SETUP = 4,
  parameter int MOVE_GAP    = 2,
  parameter int PAUSE_HOLD  = 4
) (
  input  logic             FAB_CLK,
  input  logic             RESET,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_SEL,
  input  logic             REQ_DIR,
  input  logic [TAP_W-1:0] REQ_STEPS,
  input  logic             REQ_LOAD,
  output logic             DONE_VALID,
  output logic [1:0]       DONE_STATUS,
  output logic [TAP_W-1:0] TAP_POS_TX,
  output logic [TAP_W-1:0] TAP_POS_RX,
  output logic             DELAY_LINE_SEL,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_LOAD,
  output logic             HS_IO_CLK_PAUSE,
  input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic             TX_DELAY_LINE_OUT_OF_RANGE
);
  localparam logic [TAP_W-1:0] MAX_T   = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] INIT_TX = TAP_W'(INIT_TAP_TX);
  localparam logic [TAP_W-1:0] INIT_RX = TAP_W'(INIT_TAP_RX);
  state_t           state;
  logic             load_op, load_req, accept, expired, cnt_load, last_gap, abort, to_hold, pos_we;
  logic [TAP_W-1:0] steps_left, req_pos, room, eff, pos, pos_nx, cnt_val;
`ifdef LANE_DLY_LOAD_EN
  assign load_req = REQ_LOAD;
`else
  assign load_req = REQ_LOAD & 1'b0;
`endif
  always_comb begin
    accept   = REQ_VALID && REQ_READY;
    req_pos  = REQ_SEL ? TAP_POS_TX : TAP_POS_RX;
    room     = REQ_DIR ? MAX_T - req_pos : req_pos;
    eff      = REQ_STEPS < room ? REQ_STEPS : room;
    pos      = DELAY_LINE_SEL ? TAP_POS_TX : TAP_POS_RX;
    last_gap = state == S_GAP && expired;
    abort    = last_gap && !load_op &&
               (DELAY_LINE_SEL ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE);
    to_hold  = last_gap && (abort || steps_left == '0);
    cnt_load = (state == S_IDLE && accept && (load_req || eff != '0)) || state == S_MOVE || to_hold;
    cnt_val  = state == S_IDLE ? TAP_W'(PAUSE_SETUP - 1) :
               state == S_MOVE ? TAP_W'(MOVE_GAP - 1) : TAP_W'(PAUSE_HOLD - 1);
    pos_we   = (state == S_SETUP && expired) || (last_gap && (abort || steps_left != '0));
    // an abort reverses the step that the lane controller refused
    pos_nx   = state == S_SETUP && load_op ? (DELAY_LINE_SEL ? INIT_TX : INIT_RX) :
               (DELAY_LINE_DIRECTION ^ abort) ? pos + 1'b1 : pos - 1'b1;
  end
  lane_dly_wait_cnt #(.W(TAP_W)) u_wait (
    .clk(FAB_CLK), .rst(RESET), .load(cnt_load), .val(cnt_val), .expired(expired)
  );
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      state                <= S_IDLE;
      REQ_READY            <= 1'b1;
      DONE_VALID           <= 1'b0;
      DONE_STATUS          <= ST_OK;
      DELAY_LINE_SEL       <= 1'b0;
      DELAY_LINE_DIRECTION <= 1'b0;
      DELAY_LINE_MOVE      <= 1'b0;
      DELAY_LINE_LOAD      <= 1'b0;
      HS_IO_CLK_PAUSE      <= 1'b0;
      load_op              <= 1'b0;
      steps_left           <= '0;
      TAP_POS_TX           <= INIT_TX;
      TAP_POS_RX           <= INIT_RX;
    end else begin
      if (pos_we && DELAY_LINE_SEL) TAP_POS_TX <= pos_nx;
      if (pos_we && !DELAY_LINE_SEL) TAP_POS_RX <= pos_nx;
      case (state)
        S_IDLE: if (accept) begin
          DELAY_LINE_SEL       <= REQ_SEL;
          DELAY_LINE_DIRECTION <= REQ_DIR;
          load_op              <= load_req;
          REQ_READY            <= 1'b0;
          steps_left           <= load_req ? TAP_W'(1) : eff;
          DONE_STATUS          <= !load_req && REQ_STEPS > room ? ST_CLAMP : ST_OK;
          state                <= load_req || eff != '0 ? S_SETUP : S_DONE;
          HS_IO_CLK_PAUSE      <= load_req || eff != '0;
          DONE_VALID           <= !load_req && eff == '0;
        end
        S_SETUP: if (expired) begin
          state           <= S_MOVE;
          DELAY_LINE_MOVE <= !load_op;
          DELAY_LINE_LOAD <= load_op;
        end
        S_MOVE: begin
          state           <= S_GAP;
          DELAY_LINE_MOVE <= 1'b0;
          DELAY_LINE_LOAD <= 1'b0;
          steps_left      <= steps_left - 1'b1;
        end
        S_GAP: if (expired) begin
          if (abort) DONE_STATUS <= ST_OOR;
          state           <= to_hold ? S_HOLD : S_MOVE;
          DELAY_LINE_MOVE <= !to_hold;
        end
        S_HOLD: if (expired) begin
          state           <= S_DONE;
          HS_IO_CLK_PAUSE <= 1'b0;
          DONE_VALID      <= 1'b1;
        end
        S_DONE: begin
          state      <= S_IDLE;
          DONE_VALID <= 1'b0;
          REQ_READY  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
